// File: rtl/wisc_pkg.sv
// ============================================================================
// Module      : wisc_pkg
// Description : Shared opcodes, widths and decode-state encoding for WISC.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package wisc_pkg;

    localparam int DATA_W    = 16;
    localparam int NUM_REGS  = 8;
    localparam int REG_IDX_W = $clog2(NUM_REGS);
    localparam int LINK_REG  = 7;

    localparam logic [4:0] OP_HALT   = 5'b00000;
    localparam logic [4:0] OP_NOP    = 5'b00001;
    localparam logic [4:0] OP_SIIC   = 5'b00010;
    localparam logic [4:0] OP_RTI    = 5'b00011;
    localparam logic [4:0] OP_J      = 5'b00100;
    localparam logic [4:0] OP_JR     = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b00110;
    localparam logic [4:0] OP_JALR   = 5'b00111;
    localparam logic [4:0] OP_I1_LO  = 5'b01000;
    localparam logic [4:0] OP_I1_HI  = 5'b10011;
    localparam logic [4:0] OP_SLBI   = 5'b10010;
    localparam logic [4:0] OP_LBI    = 5'b11000;
    localparam logic [4:0] OP_ALU_RR = 5'b11011;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } dec_state_e;

endpackage : wisc_pkg

`default_nettype wire

// File: rtl/regfile_bypass.sv
// ============================================================================
// Module      : regfile_bypass
// Description : Register array, two combinational read ports, write-through.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module regfile_bypass #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en_i,
    input  logic [IDX_W-1:0]  wb_reg_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [IDX_W-1:0]  rs_i,
    input  logic [IDX_W-1:0]  rt_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en_i) begin
            regs_q[wb_reg_i] <= wb_data_i;
        end
    end

    // A write landing this cycle is visible to the reader without waiting an edge.
    assign rs_data_o = (wb_en_i && (wb_reg_i == rs_i)) ? wb_data_i : regs_q[rs_i];
    assign rt_data_o = (wb_en_i && (wb_reg_i == rt_i)) ? wb_data_i : regs_q[rt_i];

endmodule : regfile_bypass

`default_nettype wire

// File: rtl/decode.sv
// ============================================================================
// Module      : decode
// Description : WISC decode stage: fields, register file, immediates, halt/err.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module decode #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int LINK_REG = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [15:0]                 instruction,
    input  logic                        wb_en,
    input  logic [$clog2(NUM_REGS)-1:0] wb_reg,
    input  logic [DATA_W-1:0]           wb_data,
    output logic [DATA_W-1:0]           read_data1,
    output logic [DATA_W-1:0]           read_data2,
    output logic [$clog2(NUM_REGS)-1:0] dest_reg,
    output logic [DATA_W-1:0]           imm5_sext,
    output logic [DATA_W-1:0]           imm5_zext,
    output logic [DATA_W-1:0]           imm8_sext,
    output logic [DATA_W-1:0]           imm8_zext,
    output logic [DATA_W-1:0]           disp11_sext,
    output logic                        halt,
    output logic                        err
);

    import wisc_pkg::*;

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [4:0]       w_opcode;
    logic [IDX_W-1:0] w_rs;
    logic [IDX_W-1:0] w_rt;
    logic             w_illegal;
    dec_state_e       state_q;
    dec_state_e       state_d;
    logic             err_q;
    logic             err_d;

    assign w_opcode  = instruction[15:11];
    assign w_rs      = IDX_W'(instruction[10:8]);
    assign w_rt      = IDX_W'(instruction[7:5]);
    assign w_illegal = (w_opcode == OP_SIIC) || (w_opcode == OP_RTI);

    regfile_bypass #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wb_en_i   (wb_en),
        .wb_reg_i  (wb_reg),
        .wb_data_i (wb_data),
        .rs_i      (w_rs),
        .rt_i      (w_rt),
        .rs_data_o (read_data1),
        .rt_data_o (read_data2)
    );

    assign imm5_sext   = {{(DATA_W-5){instruction[4]}}, instruction[4:0]};
    assign imm5_zext   = {{(DATA_W-5){1'b0}}, instruction[4:0]};
    assign imm8_sext   = {{(DATA_W-8){instruction[7]}}, instruction[7:0]};
    assign imm8_zext   = {{(DATA_W-8){1'b0}}, instruction[7:0]};
    assign disp11_sext = {{(DATA_W-11){instruction[10]}}, instruction[10:0]};

    // SLBI sits inside the I-format-1 opcode range, so it must be tested first.
    always_comb begin
        dest_reg = '0;
        if ((w_opcode == OP_JAL) || (w_opcode == OP_JALR)) begin
            dest_reg = IDX_W'(LINK_REG);
        end else if ((w_opcode == OP_LBI) || (w_opcode == OP_SLBI)) begin
            dest_reg = IDX_W'(instruction[10:8]);
        end else if ((w_opcode == OP_ALU_RR) || (w_opcode[4:2] == 3'b111)) begin
            dest_reg = IDX_W'(instruction[4:2]);
        end else if ((w_opcode >= OP_I1_LO) && (w_opcode <= OP_I1_HI)) begin
            dest_reg = IDX_W'(instruction[7:5]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (state_q == ST_RUN) begin
            if (w_opcode == OP_HALT) begin
                state_d = ST_HALTED;
            end
            if (w_illegal) begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        halt = (state_q == ST_HALTED);
        err  = err_q;
    end

endmodule : decode

`default_nettype wire
